matrix_dispatcher_mp: RTL and testbench
=======================================

Name: matrix_dispatcher_mp

Overview:
- Multi-port successor of the matrix instruction dispatcher.
- Accepts one decoded matrix instruction per handshake, latches its sideband fields and pulses a dispatch to the selected execution unit.
- Pushes every read/write operand into the per-register RW queues of the RF sequencer, up to one push per register per cycle, in parallel across registers.
- Generalised in read/write operand count; back-to-back accept in the same cycle the last operand is pushed.

Parameters:
- N_REGS, 8, number of matrix registers / RW queues.
- NUM_EXEC_UNITS, 3, number of execution units (dispatch/full vector width).
- MAX_RD_OPS, 3, maximum matrix read operands per instruction (>=1).
- MAX_WR_OPS, 2, maximum matrix writeback registers per instruction (>=1).
- ID_W, xif_pkg::X_ID_WIDTH, instruction id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_valid_i  in  1  decoder instruction valid.
- instr_ready_o  out  1  instruction accepted this cycle.
- instr_id_i / instr_id_o  in/out  ID_W  instruction id; output is latched.
- rs_i / rs_o  in/out  X_NUM_RS*X_RFR_WIDTH  scalar source operands; output is latched.
- rs_valid_i / rs_valid_o  in/out  X_NUM_RS  scalar operand valids; output is latched.
- datatype_i / datatype_o  in/out  datatype_t  element type; output is latched.
- is_store_i / is_store_o, is_float_i / is_float_o  in/out  1  operation flags; outputs are latched.
- n_rd_ops_i  in  $clog2(MAX_RD_OPS+1)  number of read operands.
- rd_regs_i / rd_regs_o  in/out  MAX_RD_OPS*$clog2(N_REGS)  read registers; output is latched.
- n_wr_ops_i  in  $clog2(MAX_WR_OPS+1)  number of writeback operands.
- wr_regs_i / wr_regs_o  in/out  MAX_WR_OPS*$clog2(N_REGS)  writeback registers; output is latched.
- exec_unit_i  in  $clog2(NUM_EXEC_UNITS)  target execution unit.
- issue_queue_full_i  in  NUM_EXEC_UNITS  per-unit issue queue full.
- dispatch_o  out  NUM_EXEC_UNITS  one-hot dispatch pulse.
- rw_queue_entry_o  out  N_REGS*rw_queue_t  per-register entry {rvalid, wready, id}.
- rw_queue_push_o  out  N_REGS  per-register push strobe.
- rw_queue_full_i  in  N_REGS  per-register queue full.
- busy_o  out  1  operands still pending.

Behaviour:
- Reset (asynchronous): state IDLE, pending mask 0, all outputs 0, datatype_o = SIZE_32.
- Operand slots: reads 0..MAX_RD_OPS-1, then writes 0..MAX_WR_OPS-1. pending is a MAX_RD_OPS+MAX_WR_OPS bit mask.
- Accept: instr_ready_o = instr_valid_i & ~issue_queue_full_i[exec_unit_i] & exec_unit_i<NUM_EXEC_UNITS & (pending==0 | pending_next==0).
- On accept:
  - Latch all *_i fields.
  - pending <= {(n_wr_ops_i>j) for each j, (n_rd_ops_i>i) for each i}. Counts above the maximum saturate to all slots.
  - Next cycle: dispatch_o[exec_unit_q]=1 for exactly one cycle.
  - An instruction with zero operands still dispatches and leaves pending=0.
- Push (combinational from registered state), for each register r:
  - Select the lowest-indexed pending slot whose register equals r. Reads precede writes, so WAR order is kept.
  - If rw_queue_full_i[r]=0: push_o[r]=1; rvalid=1 for a read slot, wready=1 for a write slot; id=instr_id_o. Clear that slot in pending_next.
  - If full: no push; retry next cycle.
  - Distinct registers push in the same cycle. Duplicate registers serialise one per cycle.
  - Never more than one push per register per cycle.
- Ordering: pending_next is computed before the accept update. An accept in the same cycle overwrites pending with the new mask; that cycle's pushes still belong to the old instruction (old id).
- State machine:
  - IDLE -> PUSH on accept with a non-zero mask.
  - PUSH -> IDLE when pending_next==0 and no accept.
  - PUSH stays in PUSH on a back-to-back accept.
- busy_o = (pending != 0).
- Reset mid-PUSH: pending is discarded, no further pushes, no dispatch.
- exec_unit_i out of range: the instruction is never accepted; a simulation assertion fires.

Decomposition:
- matrix_cps_pkg:
  - rw_queue_t and datatype_t (existing).
  - New typedef disp_slot_t {reg, is_write}.
  - Constants MAX_WR_OPERANDS and MAX_NUM_READ_OPERANDS as defaults.
- One sub-module, dispatch_reg_pick: per-register lowest-index pending-slot matcher. Inputs are the slot registers and pending mask; outputs are the per-register grant slot and the matched read/write kind. Instantiated once, vectorised over N_REGS.

Test Plan:
- Three reads of regs 1,2,3 plus one write of reg 4, no full -> push_o=0b0001_1110 in one cycle; dispatch_o=001 the cycle after accept; next instruction accepted that same cycle.
- Reads 5,5,5 -> push_o[5] in three consecutive cycles with rvalid=1; busy_o drops after the third push.
- Read 2 and write 2 -> cycle 1 push rvalid on reg 2, cycle 2 push wready on reg 2.
- rw_queue_full_i[3]=1 for 4 cycles on read 3 -> no push on reg 3 for 4 cycles, then a push in the cycle after full drops; instr_ready_o held 0 meanwhile.
- issue_queue_full_i[1]=1 with exec_unit_i=1 -> instr_ready_o=0; no latch, no push, no dispatch until full clears.
- rst_i asserted mid-PUSH with 2 slots pending -> next cycle all outputs 0, busy_o=0, no dispatch.

Source files
------------

// File: rtl/matrix_dispatcher_mp_pkg.sv
// -----------------------------------------------------------------------------
// Shared types and constants for the multi-port matrix instruction dispatcher.
//   xif_pkg        : widths of the scalar-core extension interface.
//   matrix_cps_pkg : RF-sequencer queue entry, element datatype, operand slot
//                    descriptor and default operand-count limits.
// -----------------------------------------------------------------------------
package xif_pkg;
    localparam int X_ID_WIDTH  = 4;
    localparam int X_NUM_RS    = 2;
    localparam int X_RFR_WIDTH = 32;
endpackage

package matrix_cps_pkg;
    import xif_pkg::*;

    localparam int MAX_NUM_READ_OPERANDS = 3;
    localparam int MAX_WR_OPERANDS       = 2;
    localparam int MAT_N_REGS            = 8;
    localparam int MAT_REG_W             = $clog2(MAT_N_REGS);

    typedef enum logic [1:0] {
        SIZE_8  = 2'd0,
        SIZE_16 = 2'd1,
        SIZE_32 = 2'd2,
        SIZE_64 = 2'd3
    } datatype_t;

    // One entry pushed into a per-register RW queue of the RF sequencer.
    typedef struct packed {
        logic                  rvalid;
        logic                  wready;
        logic [X_ID_WIDTH-1:0] id;
    } rw_queue_t;

    // One operand slot of the instruction in flight.
    typedef struct packed {
        logic [MAT_REG_W-1:0] reg_idx;
        logic                 is_write;
    } disp_slot_t;
endpackage

// File: rtl/matrix_dispatcher_mp_if.sv
// -----------------------------------------------------------------------------
// Decoder / execution-unit / RF-sequencer bundle of the matrix dispatcher.
//   slave  : the dispatcher side (consumes *_i, produces *_o).
//   master : the environment side (decoder, issue queues, RW queues).
// -----------------------------------------------------------------------------
interface matrix_dispatcher_mp_if
    import xif_pkg::*;
    import matrix_cps_pkg::*;
#(
    parameter int N_REGS         = MAT_N_REGS,
    parameter int NUM_EXEC_UNITS = 3,
    parameter int MAX_RD_OPS     = MAX_NUM_READ_OPERANDS,
    parameter int MAX_WR_OPS     = MAX_WR_OPERANDS,
    parameter int ID_W           = X_ID_WIDTH
);
    localparam int REG_W    = $clog2(N_REGS);
    localparam int RD_CNT_W = $clog2(MAX_RD_OPS + 1);
    localparam int WR_CNT_W = $clog2(MAX_WR_OPS + 1);
    localparam int EU_W     = $clog2(NUM_EXEC_UNITS);

    logic                            instr_valid_i;
    logic                            instr_ready_o;
    logic [ID_W-1:0]                 instr_id_i;
    logic [ID_W-1:0]                 instr_id_o;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_i;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_o;
    logic [X_NUM_RS-1:0]             rs_valid_i;
    logic [X_NUM_RS-1:0]             rs_valid_o;
    datatype_t                       datatype_i;
    datatype_t                       datatype_o;
    logic                            is_store_i;
    logic                            is_store_o;
    logic                            is_float_i;
    logic                            is_float_o;
    logic [RD_CNT_W-1:0]             n_rd_ops_i;
    logic [MAX_RD_OPS*REG_W-1:0]     rd_regs_i;
    logic [MAX_RD_OPS*REG_W-1:0]     rd_regs_o;
    logic [WR_CNT_W-1:0]             n_wr_ops_i;
    logic [MAX_WR_OPS*REG_W-1:0]     wr_regs_i;
    logic [MAX_WR_OPS*REG_W-1:0]     wr_regs_o;
    logic [EU_W-1:0]                 exec_unit_i;
    logic [NUM_EXEC_UNITS-1:0]       issue_queue_full_i;
    logic [NUM_EXEC_UNITS-1:0]       dispatch_o;
    rw_queue_t [N_REGS-1:0]          rw_queue_entry_o;
    logic [N_REGS-1:0]               rw_queue_push_o;
    logic [N_REGS-1:0]               rw_queue_full_i;
    logic                            busy_o;

    modport slave (
        input  instr_valid_i, instr_id_i, rs_i, rs_valid_i, datatype_i,
               is_store_i, is_float_i, n_rd_ops_i, rd_regs_i, n_wr_ops_i,
               wr_regs_i, exec_unit_i, issue_queue_full_i, rw_queue_full_i,
        output instr_ready_o, instr_id_o, rs_o, rs_valid_o, datatype_o,
               is_store_o, is_float_o, rd_regs_o, wr_regs_o, dispatch_o,
               rw_queue_entry_o, rw_queue_push_o, busy_o
    );

    modport master (
        output instr_valid_i, instr_id_i, rs_i, rs_valid_i, datatype_i,
               is_store_i, is_float_i, n_rd_ops_i, rd_regs_i, n_wr_ops_i,
               wr_regs_i, exec_unit_i, issue_queue_full_i, rw_queue_full_i,
        input  instr_ready_o, instr_id_o, rs_o, rs_valid_o, datatype_o,
               is_store_o, is_float_o, rd_regs_o, wr_regs_o, dispatch_o,
               rw_queue_entry_o, rw_queue_push_o, busy_o
    );
endinterface

// File: rtl/matrix_dispatcher_mp_pick.sv
// -----------------------------------------------------------------------------
// dispatch_reg_pick: for every matrix register, find the lowest-indexed
// pending operand slot that names it.
//   slots_i          : register/kind of every operand slot (reads first).
//   pending_i        : slots still to be pushed.
//   grant_valid_o    : register r has a pending slot.
//   grant_slot_o     : index of that slot.
//   grant_is_write_o : that slot is a writeback operand.
// -----------------------------------------------------------------------------
module dispatch_reg_pick
    import matrix_cps_pkg::*;
#(
    parameter int N_REGS  = MAT_N_REGS,
    parameter int N_SLOTS = MAX_NUM_READ_OPERANDS + MAX_WR_OPERANDS,
    parameter int SLOT_W  = $clog2(N_SLOTS)
) (
    input  disp_slot_t [N_SLOTS-1:0]          slots_i,
    input  logic       [N_SLOTS-1:0]          pending_i,
    output logic       [N_REGS-1:0]           grant_valid_o,
    output logic       [N_REGS-1:0][SLOT_W-1:0] grant_slot_o,
    output logic       [N_REGS-1:0]           grant_is_write_o
);
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves it unassigned would infer a latch.
    always_comb begin
        grant_valid_o    = '0;
        grant_slot_o     = '0;
        grant_is_write_o = '0;
        for (int r = 0; r < N_REGS; r++) begin
            // Scan from the top so the lowest matching slot is written last.
            for (int s = N_SLOTS - 1; s >= 0; s--) begin
                if (pending_i[s] && slots_i[s].reg_idx == MAT_REG_W'(r)) begin
                    grant_valid_o[r]    = 1'b1;
                    grant_slot_o[r]     = SLOT_W'(s);
                    grant_is_write_o[r] = slots_i[s].is_write;
                end
            end
        end
    end
endmodule

// File: rtl/matrix_dispatcher_mp.sv
// -----------------------------------------------------------------------------
// matrix_dispatcher_mp: accepts one decoded matrix instruction per handshake,
// latches its sideband fields, pulses a one-cycle dispatch to the selected
// execution unit and pushes every read/write operand into the per-register RW
// queues (at most one push per register per cycle, registers in parallel).
//   clk_i, rst_i : clock, asynchronous active-high reset.
//   bus (slave)  : decoder handshake + fields, latched field outputs,
//                  issue-queue full / dispatch, RW-queue entry/push/full, busy.
// -----------------------------------------------------------------------------
module matrix_dispatcher_mp
    import xif_pkg::*;
    import matrix_cps_pkg::*;
#(
    parameter int N_REGS         = MAT_N_REGS,
    parameter int NUM_EXEC_UNITS = 3,
    parameter int MAX_RD_OPS     = MAX_NUM_READ_OPERANDS,
    parameter int MAX_WR_OPS     = MAX_WR_OPERANDS,
    parameter int ID_W           = X_ID_WIDTH
) (
    input logic                   clk_i,
    input logic                   rst_i,
    matrix_dispatcher_mp_if.slave bus
);
    localparam int N_SLOTS = MAX_RD_OPS + MAX_WR_OPS;
    localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int REG_W   = $clog2(N_REGS);
    localparam int EU_W    = $clog2(NUM_EXEC_UNITS);

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [N_SLOTS-1:0]              pending_q, pending_d, pending_next;
    logic [N_SLOTS-1:0]              new_mask, push_clear;
    logic [NUM_EXEC_UNITS-1:0]       dispatch_q, dispatch_d;

    logic [ID_W-1:0]                 instr_id_q;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_q;
    logic [X_NUM_RS-1:0]             rs_valid_q;
    datatype_t                       datatype_q;
    logic                            is_store_q, is_float_q;
    logic [MAX_RD_OPS*REG_W-1:0]     rd_regs_q;
    logic [MAX_WR_OPS*REG_W-1:0]     wr_regs_q;

    disp_slot_t [N_SLOTS-1:0]        slots;
    logic [N_REGS-1:0]               grant_valid, grant_is_write, push;
    logic [N_REGS-1:0][SLOT_W-1:0]   grant_slot;
    rw_queue_t [N_REGS-1:0]          entry;
    logic                            unit_ok, unit_full, accept;

    // Operand slots of the instruction in flight: reads, then writes.
    always_comb begin
        slots = '0;
        for (int i = 0; i < MAX_RD_OPS; i++) begin
            slots[i].reg_idx  = MAT_REG_W'(rd_regs_q[i*REG_W +: REG_W]);
            slots[i].is_write = 1'b0;
        end
        for (int j = 0; j < MAX_WR_OPS; j++) begin
            slots[MAX_RD_OPS+j].reg_idx  = MAT_REG_W'(wr_regs_q[j*REG_W +: REG_W]);
            slots[MAX_RD_OPS+j].is_write = 1'b1;
        end
    end

    dispatch_reg_pick #(
        .N_REGS  (N_REGS),
        .N_SLOTS (N_SLOTS),
        .SLOT_W  (SLOT_W)
    ) u_pick (
        .slots_i          (slots),
        .pending_i        (pending_q),
        .grant_valid_o    (grant_valid),
        .grant_slot_o     (grant_slot),
        .grant_is_write_o (grant_is_write)
    );

    // Pushes always belong to the registered instruction, even when a new
    // one is accepted in the same cycle.
    always_comb begin
        push       = '0;
        push_clear = '0;
        entry      = '0;
        for (int r = 0; r < N_REGS; r++) begin
            push[r] = grant_valid[r] & ~bus.rw_queue_full_i[r];
            if (push[r]) begin
                entry[r].rvalid        = ~grant_is_write[r];
                entry[r].wready        = grant_is_write[r];
                entry[r].id            = instr_id_q;
                push_clear[grant_slot[r]] = 1'b1;
            end
        end
        pending_next = pending_q & ~push_clear;
    end

    // Accept decision, new operand mask and state machine.
    always_comb begin
        new_mask  = '0;
        unit_full = 1'b0;
        for (int i = 0; i < MAX_RD_OPS; i++)
            new_mask[i] = (32'(bus.n_rd_ops_i) > i);
        for (int j = 0; j < MAX_WR_OPS; j++)
            new_mask[MAX_RD_OPS+j] = (32'(bus.n_wr_ops_i) > j);
        for (int u = 0; u < NUM_EXEC_UNITS; u++)
            if (32'(bus.exec_unit_i) == u)
                unit_full = bus.issue_queue_full_i[u];
        unit_ok = (32'(bus.exec_unit_i) < NUM_EXEC_UNITS);
        accept  = bus.instr_valid_i & unit_ok & ~unit_full &
                  ((pending_q == '0) | (pending_next == '0));

        state_d    = state_q;
        pending_d  = pending_next;
        dispatch_d = '0;
        case (state_q)
            IDLE:    if (accept && new_mask != '0) state_d = PUSH;
            PUSH:    if (!accept && pending_next == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            pending_d  = new_mask;
            dispatch_d = NUM_EXEC_UNITS'(1) << bus.exec_unit_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            dispatch_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            dispatch_q <= dispatch_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_id_q <= '0;
            rs_q       <= '0;
            rs_valid_q <= '0;
            datatype_q <= SIZE_32;
            is_store_q <= 1'b0;
            is_float_q <= 1'b0;
            rd_regs_q  <= '0;
            wr_regs_q  <= '0;
        end else if (accept) begin
            instr_id_q <= bus.instr_id_i;
            rs_q       <= bus.rs_i;
            rs_valid_q <= bus.rs_valid_i;
            datatype_q <= bus.datatype_i;
            is_store_q <= bus.is_store_i;
            is_float_q <= bus.is_float_i;
            rd_regs_q  <= bus.rd_regs_i;
            wr_regs_q  <= bus.wr_regs_i;
        end
    end

    assign bus.instr_ready_o    = accept;
    assign bus.instr_id_o       = instr_id_q;
    assign bus.rs_o             = rs_q;
    assign bus.rs_valid_o       = rs_valid_q;
    assign bus.datatype_o       = datatype_q;
    assign bus.is_store_o       = is_store_q;
    assign bus.is_float_o       = is_float_q;
    assign bus.rd_regs_o        = rd_regs_q;
    assign bus.wr_regs_o        = wr_regs_q;
    assign bus.dispatch_o       = dispatch_q;
    assign bus.rw_queue_entry_o = entry;
    assign bus.rw_queue_push_o  = push;
    assign bus.busy_o           = (pending_q != '0);

    // An instruction aimed at a non-existent unit would stall the decoder.
    a_exec_unit_range: assert property (
        @(posedge clk_i) disable iff (rst_i) bus.instr_valid_i |-> unit_ok
    );

    localparam int EU_W_USED = EU_W;
endmodule

// File: tb/tb_matrix_dispatcher_mp.sv
// -----------------------------------------------------------------------------
// Testbench for matrix_dispatcher_mp. A reference model keeps one FIFO of
// pending operations per register; every cycle the head of each non-full FIFO
// is expected as that register's push.
// -----------------------------------------------------------------------------
module tb_matrix_dispatcher_mp;
    import xif_pkg::*;
    import matrix_cps_pkg::*;

    localparam int N_REGS = 8;
    localparam int NUM_EU = 3;
    localparam int MAX_RD = 3;
    localparam int MAX_WR = 2;
    localparam int REG_W  = 3;
    localparam int ID_W   = X_ID_WIDTH;
    localparam int ENT_W  = $bits(rw_queue_t);

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    matrix_dispatcher_mp_if bus ();

    matrix_dispatcher_mp dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // ---------------- reference model state ----------------
    bit                              mq [N_REGS][$];  // 0 = read, 1 = write
    logic [ID_W-1:0]                 m_id;
    datatype_t                       m_dt;
    logic                            m_store, m_float;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] m_rs;
    logic [X_NUM_RS-1:0]             m_rsv;
    logic [MAX_RD*REG_W-1:0]         m_rd;
    logic [MAX_WR*REG_W-1:0]         m_wr;
    logic [NUM_EU-1:0]               m_disp;

    int n_vec = 0;
    int n_err = 0;

    logic              obs_ready, obs_busy;
    logic [N_REGS-1:0] obs_push;
    logic [NUM_EU-1:0] obs_disp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N_REGS; r++) mq[r].delete();
        m_id = '0; m_dt = SIZE_32; m_store = 1'b0; m_float = 1'b0;
        m_rs = '0; m_rsv = '0; m_rd = '0; m_wr = '0; m_disp = '0;
    endtask

    // Compare this cycle's outputs, then advance the model to the next edge.
    task automatic model_cycle();
        logic [N_REGS-1:0]       e_push;
        logic [N_REGS*ENT_W-1:0] e_ent, a_ent;
        rw_queue_t               ent;
        int                      total, remaining, eu, n;
        logic                    e_ready;
        if (rst_i) model_reset();
        total  = 0;
        e_push = '0;
        e_ent  = '0;
        for (int r = 0; r < N_REGS; r++) begin
            total += mq[r].size();
            if (mq[r].size() > 0 && !bus.rw_queue_full_i[r]) begin
                e_push[r]  = 1'b1;
                ent        = '0;
                ent.rvalid = !mq[r][0];
                ent.wready = mq[r][0];
                ent.id     = m_id;
                e_ent[r*ENT_W +: ENT_W] = ent;
            end
            a_ent[r*ENT_W +: ENT_W] = bus.rw_queue_entry_o[r];
        end
        remaining = total - $countones(e_push);
        eu        = int'(bus.exec_unit_i);
        e_ready   = bus.instr_valid_i && eu < NUM_EU && !bus.issue_queue_full_i[eu] &&
                    (total == 0 || remaining == 0);

        check("ready",    64'(bus.instr_ready_o),   64'(e_ready));
        check("push",     64'(bus.rw_queue_push_o), 64'(e_push));
        check("entries",  64'(a_ent),               64'(e_ent));
        check("dispatch", 64'(bus.dispatch_o),      64'(m_disp));
        check("busy",     64'(bus.busy_o),          64'(total != 0));
        check("id_o",     64'(bus.instr_id_o),      64'(m_id));
        check("rs_o",     64'(bus.rs_o),            64'(m_rs));
        check("fields_o",
              64'({bus.datatype_o, bus.is_store_o, bus.is_float_o, bus.rs_valid_o, bus.rd_regs_o, bus.wr_regs_o}),
              64'({m_dt, m_store, m_float, m_rsv, m_rd, m_wr}));

        obs_ready = bus.instr_ready_o;
        obs_busy  = bus.busy_o;
        obs_push  = bus.rw_queue_push_o;
        obs_disp  = bus.dispatch_o;

        if (!rst_i) begin
            for (int r = 0; r < N_REGS; r++)
                if (e_push[r]) void'(mq[r].pop_front());
            m_disp = '0;
            if (e_ready) begin
                n = int'(bus.n_rd_ops_i);
                for (int i = 0; i < n && i < MAX_RD; i++)
                    mq[int'(bus.rd_regs_i[i*REG_W +: REG_W])].push_back(1'b0);
                n = int'(bus.n_wr_ops_i);
                for (int j = 0; j < n && j < MAX_WR; j++)
                    mq[int'(bus.wr_regs_i[j*REG_W +: REG_W])].push_back(1'b1);
                m_disp[eu] = 1'b1;
                m_id    = bus.instr_id_i;
                m_dt    = bus.datatype_i;
                m_store = bus.is_store_i;
                m_float = bus.is_float_i;
                m_rs    = bus.rs_i;
                m_rsv   = bus.rs_valid_i;
                m_rd    = bus.rd_regs_i;
                m_wr    = bus.wr_regs_i;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        model_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_instr(input int n_rd, input int r0, input int r1, input int r2,
                               input int n_wr, input int w0, input int w1, input int eu);
        bus.instr_valid_i = 1'b1;
        bus.n_rd_ops_i    = 2'(n_rd);
        bus.rd_regs_i     = {3'(r2), 3'(r1), 3'(r0)};
        bus.n_wr_ops_i    = 2'(n_wr);
        bus.wr_regs_i     = {3'(w1), 3'(w0)};
        bus.exec_unit_i   = 2'(eu);
        bus.instr_id_i    = ID_W'($urandom);
        bus.rs_i          = {$urandom, $urandom};
        bus.rs_valid_i    = 2'($urandom);
        bus.datatype_i    = datatype_t'($urandom_range(0, 3));
        bus.is_store_i    = 1'($urandom);
        bus.is_float_i    = 1'($urandom);
    endtask

    typedef struct {
        int         n_rd;
        int         rd0, rd1, rd2;
        int         n_wr;
        int         wr0, wr1;
        logic [7:0] exp_push;   // push mask in the cycle after accept
        int         exp_busy;   // cycles with busy_o high
    } vec_t;

    vec_t tbl [5];
    int   busy_cycles;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3, 1, 2, 3, 1, 4, 0, 8'b0001_1110, 1};  // parallel pushes
        tbl[1] = '{3, 5, 5, 5, 0, 0, 0, 8'b0010_0000, 3};  // duplicate reads serialise
        tbl[2] = '{1, 2, 0, 0, 1, 2, 0, 8'b0000_0100, 2};  // read then write, same reg
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, 0};  // no operands
        tbl[4] = '{3, 0, 7, 0, 3, 7, 6, 8'b1100_0001, 2};  // saturated write count

        bus.instr_valid_i      = 1'b0;
        bus.instr_id_i         = '0;
        bus.rs_i               = '0;
        bus.rs_valid_i         = '0;
        bus.datatype_i         = SIZE_8;
        bus.is_store_i         = 1'b0;
        bus.is_float_i         = 1'b0;
        bus.n_rd_ops_i         = '0;
        bus.rd_regs_i          = '0;
        bus.n_wr_ops_i         = '0;
        bus.wr_regs_i          = '0;
        bus.exec_unit_i        = '0;
        bus.issue_queue_full_i = '0;
        bus.rw_queue_full_i    = '0;
        model_reset();

        // Reset state.
        tick();
        check("reset_datatype", 64'(bus.datatype_o), 64'(SIZE_32));
        tick();
        rst_i = 1'b0;
        tick();

        // Table-driven single instructions.
        for (int k = 0; k < 5; k++) begin
            drive_instr(tbl[k].n_rd, tbl[k].rd0, tbl[k].rd1, tbl[k].rd2,
                        tbl[k].n_wr, tbl[k].wr0, tbl[k].wr1, k % NUM_EU);
            tick();
            check("tbl_accept", 64'(obs_ready), 64'(1));
            bus.instr_valid_i = 1'b0;
            tick();
            check("tbl_first_push", 64'(obs_push), 64'(tbl[k].exp_push));
            check("tbl_dispatch",   64'(obs_disp), 64'(1 << (k % NUM_EU)));
            busy_cycles = 0;
            for (int g = 0; g < 20 && obs_busy; g++) begin
                busy_cycles++;
                tick();
            end
            check("tbl_busy_cycles", 64'(busy_cycles), 64'(tbl[k].exp_busy));
        end

        // Back-to-back accept in the cycle the last operands are pushed.
        drive_instr(3, 1, 2, 3, 1, 4, 0, 0);
        tick();
        drive_instr(1, 0, 0, 0, 0, 0, 0, 2);
        tick();
        check("b2b_dispatch", 64'(obs_disp),  64'(3'b001));
        check("b2b_push",     64'(obs_push),  64'(8'h1E));
        check("b2b_ready",    64'(obs_ready), 64'(1));
        bus.instr_valid_i = 1'b0;
        tick();
        check("b2b_second_push", 64'(obs_push), 64'(8'h01));
        check("b2b_second_disp", 64'(obs_disp), 64'(3'b100));
        tick();

        // RW queue full on the only operand register.
        drive_instr(1, 3, 0, 0, 0, 0, 0, 1);
        tick();
        bus.rw_queue_full_i = 8'b0000_1000;
        drive_instr(1, 6, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("full_no_push", 64'(obs_push[3]), 64'(0));
            check("full_no_ready", 64'(obs_ready), 64'(0));
        end
        bus.rw_queue_full_i = '0;
        tick();
        check("full_release_push",  64'(obs_push),  64'(8'h08));
        check("full_release_ready", 64'(obs_ready), 64'(1));
        bus.instr_valid_i = 1'b0;
        tick();
        tick();

        // Issue queue full on the target unit.
        bus.issue_queue_full_i = 3'b010;
        drive_instr(1, 4, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("iq_full_ready", 64'(obs_ready), 64'(0));
            check("iq_full_push",  64'(obs_push),  64'(0));
            check("iq_full_disp",  64'(obs_disp),  64'(0));
        end
        bus.issue_queue_full_i = '0;
        tick();
        check("iq_clear_ready", 64'(obs_ready), 64'(1));
        bus.instr_valid_i = 1'b0;
        tick();
        check("iq_clear_disp", 64'(obs_disp), 64'(3'b010));
        check("iq_clear_push", 64'(obs_push), 64'(8'h10));
        tick();

        // Reset with two slots still pending.
        drive_instr(3, 5, 5, 5, 0, 0, 0, 0);
        tick();
        bus.instr_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        check("rst_push", 64'(obs_push), 64'(0));
        check("rst_busy", 64'(obs_busy), 64'(0));
        check("rst_disp", 64'(obs_disp), 64'(0));
        rst_i = 1'b0;
        tick();
        check("post_rst_push", 64'(obs_push), 64'(0));
        check("post_rst_busy", 64'(obs_busy), 64'(0));

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            drive_instr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, NUM_EU - 1));
            bus.instr_valid_i      = ($urandom_range(0, 3) != 0);
            bus.issue_queue_full_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            for (int r = 0; r < N_REGS; r++)
                bus.rw_queue_full_i[r] = ($urandom_range(0, 4) == 0);
            tick();
        end
        bus.instr_valid_i   = 1'b0;
        bus.rw_queue_full_i = '0;
        for (int c = 0; c < 10; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
